csa_sbox_share_arb: RTL and testbench
=====================================

// Module: csa_sbox_share_arb
// PURPOSE
//   Shares one registered bank of the seven CSA S-boxes (sbox1..sbox7, 5-bit in -> 2-bit out each)
//   between two requesters, port A (block-cipher side) and port B (stream-cipher side).
//   Arbitration is round-robin with a req/gnt handshake. Each response is tagged back to its
//   requester after a fixed pipeline latency. Saves one full S-box bank per CSA core.
// PARAMETERS
//   LAT      2    request-to-response latency in cycles; legal values are 1 or 2
//   CNT_W    16   width of the saturating grant counters
// PORTS
//   clk        in   1      clock; all state updates on the rising edge
//   rst        in   1      asynchronous, active-high reset
//   req_a      in   1      port A request; held high with in_a stable until gnt_a
//   in_a       in   35     port A lookup word; lane k = bits [5k+4:5k] feeds sbox(k+1)
//   gnt_a      out  1      combinational; port A request accepted this cycle
//   rsp_vld_a  out  1      port A response valid (one-cycle pulse per grant)
//   rsp_a      out  14     port A result; lane k = bits [2k+1:2k] from sbox(k+1)
//   req_b      in   1      port B request (same rules as A)
//   in_b       in   35     port B lookup word
//   gnt_b      out  1      port B request accepted this cycle
//   rsp_vld_b  out  1      port B response valid
//   rsp_b      out  14     port B result
//   busy       out  1      high while any granted lookup is still in the pipeline
//   cnt_a      out  CNT_W  number of grants to A; saturates at all-ones
//   cnt_b      out  CNT_W  number of grants to B; saturates at all-ones
// BEHAVIOUR
//   Reset: all outputs are 0. rr_last = B, so A wins the first contention.
//     Pipeline valid bits and tags clear immediately. In-flight lookups are discarded with no response.
//   Arbitration is combinational from req_a, req_b and rr_last:
//     - only one requester: that requester is granted;
//     - both requesting: grant the port not equal to rr_last;
//     - at most one grant per cycle; gnt_x is never high without req_x;
//     - on any grant, rr_last <= granted port.
//   Stage 0 (grant edge): the S-box input register captures the granted word; tag <= port; v0 <= 1.
//   LAT=1: registered S-box outputs drive rsp_x in the cycle after the grant.
//     rsp_vld_x = v0 && tag==x.
//   LAT=2: one extra output register. Response appears 2 cycles after the grant.
//   Throughput: one lookup per cycle, with back-to-back grants allowed.
//     Alternating A,B under continuous contention.
//   rsp_x holds its last value when rsp_vld_x is low. rsp_vld_a and rsp_vld_b are never high together.
//   No response backpressure; requesters must accept rsp_vld_x unconditionally.
//   busy = OR of all pipeline valid bits.
//   cnt_x increments on each gnt_x and stops at 2^CNT_W-1. It never wraps.
//   S-box lanes are pure lookup tables: identical input always gives identical output, whichever port.
//   Dropping req_x before gnt_x withdraws the request; no state change.
// TESTING
//   1. Reset, then req_a=1, in_a lane4=5'h03, other lanes 0.
//      -> gnt_a same cycle. LAT=2: rsp_vld_a at +2, rsp_a[9:8]=2'h1.
//   2. req_a=req_b=1 held for 6 cycles.
//      -> grants A,B,A,B,A,B; responses in the same order; no cycle with both rsp_vld.
//   3. Only req_b active for 4 cycles, lane4 inputs 5'h00, 5'h1f, 5'h04, 5'h0a.
//      -> 4 back-to-back grants; rsp_b[9:8] = 2,2,3,3.
//   4. Assert rst one cycle after a grant.
//      -> no rsp_vld pulse for that lookup; busy=0 and cnt_a=cnt_b=0 immediately;
//      A wins the next contention.
//   5. CNT_W=4, 20 A grants -> cnt_a sticks at 4'hF; cnt_b stays 0.
//   6. Random req and data on both ports for 10k cycles.
//      -> every grant yields exactly one response on its own port after LAT cycles,
//      matching a sbox1..sbox7 reference model; no starvation exceeding 1 cycle.

Source files
------------

// File: rtl/csa_sbox_share_arb.sv
// One registered bank of the seven CSA stream S-boxes shared by two requesters
// through a round-robin req/gnt arbiter; results are tagged back to their port.
module csa_sbox_share_arb #(
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [34:0]      in_a,
  output logic             gnt_a,
  output logic             rsp_vld_a,
  output logic [13:0]      rsp_a,
  input  logic             req_b,
  input  logic [34:0]      in_b,
  output logic             gnt_b,
  output logic             rsp_vld_b,
  output logic [13:0]      rsp_b,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [1:0] SBOX [0:6][0:31] = '{
    '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
    '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
    '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
    '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
    '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
    '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
    '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
  };

  function automatic logic [13:0] lookup(input logic [34:0] w);
    logic [13:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r[2*k +: 2] = SBOX[k][w[5*k +: 5]];
    return r;
  endfunction

  // rr_last: 0 = A was granted last, 1 = B was granted last
  logic        rr_last;
  logic [34:0] in_q;
  logic        tag_q;
  logic        v0;
  logic [13:0] sb_out;

  // Strict handshake: gnt_x is a same-cycle, combinational accept of a held req_x.
  assign gnt_a = req_a & (~req_b | rr_last);
  assign gnt_b = req_b & (~req_a | ~rr_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= 1'b1;
      in_q    <= '0;
      tag_q   <= 1'b0;
      v0      <= 1'b0;
    end else begin
      v0 <= gnt_a | gnt_b;
      if (gnt_a | gnt_b) begin
        rr_last <= gnt_b;
        in_q    <= gnt_b ? in_b : in_a;
        tag_q   <= gnt_b;
      end
    end
  end

  assign sb_out = lookup(in_q);

  logic        vld_a_q, vld_b_q;
  logic [13:0] rsp_a_q, rsp_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      vld_a_q <= (LAT != 1) && v0 && !tag_q;
      vld_b_q <= (LAT != 1) && v0 && tag_q;
      if (v0 && !tag_q) rsp_a_q <= sb_out;
      if (v0 && tag_q)  rsp_b_q <= sb_out;
    end
  end

  // With LAT=1 the lookup passes straight out; the registers only hold the last result.
  generate
    if (LAT == 1) begin : g_lat1
      assign rsp_vld_a = v0 & ~tag_q;
      assign rsp_vld_b = v0 & tag_q;
      assign rsp_a     = rsp_vld_a ? sb_out : rsp_a_q;
      assign rsp_b     = rsp_vld_b ? sb_out : rsp_b_q;
    end else begin : g_lat2
      assign rsp_vld_a = vld_a_q;
      assign rsp_vld_b = vld_b_q;
      assign rsp_a     = rsp_a_q;
      assign rsp_b     = rsp_b_q;
    end
  endgenerate

  assign busy = v0 | vld_a_q | vld_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (gnt_a && cnt_a != {CNT_W{1'b1}}) cnt_a <= cnt_a + 1'b1;
      if (gnt_b && cnt_b != {CNT_W{1'b1}}) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: tb/tb_csa_sbox_share_arb.sv
// Bench for the shared CSA S-box arbiter: directed scenarios plus a long random
// run checked against a table-driven reference model.
module tb_csa_sbox_share_arb;

  localparam int LAT   = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [34:0]      in_a = '0, in_b = '0;
  logic             gnt_a, gnt_b, rsp_vld_a, rsp_vld_b, busy;
  logic [13:0]      rsp_a, rsp_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int sb [0:6][0:31] = '{
    '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
    '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
    '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
    '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
    '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
    '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
    '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
  };

  csa_sbox_share_arb #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .in_a(in_a), .gnt_a(gnt_a), .rsp_vld_a(rsp_vld_a), .rsp_a(rsp_a),
    .req_b(req_b), .in_b(in_b), .gnt_b(gnt_b), .rsp_vld_b(rsp_vld_b), .rsp_b(rsp_b),
    .busy(busy), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result: each 5-bit lane indexes its own table, result lanes are 2 bits wide.
  function automatic logic [13:0] ref_lookup(input logic [34:0] w);
    int v;
    logic [13:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) begin
      v = int'((w >> (5 * k)) & 35'h1f);
      r = r | (14'(sb[k][v]) << (2 * k));
    end
    return r;
  endfunction

  function automatic logic [34:0] rand_word();
    return 35'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({gnt_a, gnt_b, rsp_vld_a, rsp_vld_b, busy} !== 5'b0 || rsp_a !== 14'h0 || rsp_b !== 14'h0 ||
        cnt_a !== '0 || cnt_b !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got flags=%b rsp_a=%h rsp_b=%h cnt_a=%0d cnt_b=%0d, need all zero",
               {gnt_a, gnt_b, rsp_vld_a, rsp_vld_b, busy}, rsp_a, rsp_b, cnt_a, cnt_b);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    req_a = 1'b1; in_a = 35'(5'h03) << 20;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt_a=%b gnt_b=%b, need 1 0", gnt_a, gnt_b);
    end
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_vld_a !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_plus1: got rsp_vld_a=%b busy=%b, need 0 1", rsp_vld_a, busy);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_vld_a !== 1'b1 || rsp_a[9:8] !== 2'h1 || rsp_a !== ref_lookup(35'(5'h03) << 20)) begin
      n_fail++;
      $display("FAIL single_rsp: got vld=%b rsp_a=%h, need 1 %h", rsp_vld_a, rsp_a,
               ref_lookup(35'(5'h03) << 20));
    end
    @(negedge clk);
    n_checks++;
    if (rsp_vld_a !== 1'b0 || busy !== 1'b0 || cnt_a !== 4'd1) begin
      n_fail++;
      $display("FAIL single_after: got vld=%b busy=%b cnt_a=%0d, need 0 0 1", rsp_vld_a, busy, cnt_a);
    end
  endtask

  task automatic test_contention();
    logic [13:0] exp_v [0:5];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 6) begin
        req_a = 1'b1; req_b = 1'b1;
        if (i % 2 == 0) in_a = rand_word();
        if (i == 0 || i % 2 == 1) in_b = rand_word();
      end else begin
        req_a = 1'b0; req_b = 1'b0;
      end
      @(negedge clk);
      if (i < 6) begin
        exp_v[i] = ref_lookup((i % 2 == 0) ? in_a : in_b);
        n_checks++;
        if (gnt_a !== (i % 2 == 0) || gnt_b !== (i % 2 == 1)) begin
          n_fail++;
          $display("FAIL contention_gnt[%0d]: got a=%b b=%b, need a=%0d", i, gnt_a, gnt_b, i % 2 == 0);
        end
      end
      if (i >= 2) begin
        n_checks++;
        if ((i % 2 == 0) ? (rsp_vld_a !== 1'b1 || rsp_vld_b !== 1'b0 || rsp_a !== exp_v[i-2])
                         : (rsp_vld_b !== 1'b1 || rsp_vld_a !== 1'b0 || rsp_b !== exp_v[i-2])) begin
          n_fail++;
          $display("FAIL contention_rsp[%0d]: got vld_a=%b vld_b=%b rsp_a=%h rsp_b=%h, need %h on %s",
                   i - 2, rsp_vld_a, rsp_vld_b, rsp_a, rsp_b, exp_v[i-2], (i % 2 == 0) ? "A" : "B");
        end
      end
    end
  endtask

  task automatic test_b_stream();
    logic [4:0] lane [0:3];
    logic [1:0] exp_o [0:3];
    lane = '{5'h00, 5'h1f, 5'h04, 5'h0a};
    exp_o = '{2'd2, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_b = (i < 4);
      if (i < 4) in_b = 35'(lane[i]) << 20;
      @(negedge clk);
      if (i < 4) begin
        n_checks++;
        if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
          n_fail++;
          $display("FAIL bstream_gnt[%0d]: got gnt_b=%b gnt_a=%b, need 1 0", i, gnt_b, gnt_a);
        end
      end
      if (i >= 2) begin
        n_checks++;
        if (rsp_vld_b !== 1'b1 || rsp_vld_a !== 1'b0 || rsp_b[9:8] !== exp_o[i-2]) begin
          n_fail++;
          $display("FAIL bstream_rsp[%0d]: got vld=%b lane4=%0d, need 1 %0d", i - 2, rsp_vld_b,
                   rsp_b[9:8], exp_o[i-2]);
        end
      end
    end
    req_b = 1'b0;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    @(posedge clk); #1;
    req_a = 1'b1; in_a = rand_word();
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_gnt: got %b, need 1", gnt_a);
    end
    @(posedge clk); #1;
    req_a = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || cnt_a !== '0 || cnt_b !== '0 || rsp_vld_a !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_rst: got busy=%b cnt_a=%0d cnt_b=%0d vld_a=%b, need all 0",
               busy, cnt_a, cnt_b, rsp_vld_a);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_vld_a !== 1'b0 || rsp_vld_b !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_drop[%0d]: got vld_a=%b vld_b=%b busy=%b, need 0", i,
                 rsp_vld_a, rsp_vld_b, busy);
      end
    end
    @(posedge clk); #1;
    req_a = 1'b1; req_b = 1'b1;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_next: got gnt_a=%b gnt_b=%b, need 1 0", gnt_a, gnt_b);
    end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_c;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      req_a = 1'b1; in_a = rand_word();
      @(negedge clk);
      exp_c = (i > 15) ? 15 : i;
      n_checks++;
      if (gnt_a !== 1'b1 || int'(cnt_a) != exp_c || cnt_b !== '0) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got gnt_a=%b cnt_a=%0d cnt_b=%0d, need 1 %0d 0", i, gnt_a,
                 cnt_a, cnt_b, exp_c);
      end
    end
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cnt_a !== 4'hf || cnt_b !== 4'h0) begin
      n_fail++;
      $display("FAIL saturate_final: got cnt_a=%h cnt_b=%h, need f 0", cnt_a, cnt_b);
    end
  endtask

  task automatic test_random();
    logic [13:0] exp_qa[$], exp_qb[$];
    int          due_qa[$], due_qb[$];
    logic [13:0] last_a, last_b;
    bit          m_last_b;
    int          m_cnt_a, m_cnt_b, wait_a, wait_b;
    bit          pend_a, pend_b, eg_a, eg_b, ev_a, ev_b, e_busy;
    logic [13:0] ea, eb;
    do_reset();
    m_last_b = 1'b1; m_cnt_a = 0; m_cnt_b = 0; wait_a = 0; wait_b = 0;
    last_a = '0; last_b = '0; pend_a = 1'b0; pend_b = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (i >= 9996) begin
        req_a = 1'b0; req_b = 1'b0;
      end else begin
        if (!(pend_a && $urandom_range(0, 7) != 0)) begin
          req_a = 1'($urandom_range(0, 1)); in_a = rand_word();
        end
        if (!(pend_b && $urandom_range(0, 7) != 0)) begin
          req_b = 1'($urandom_range(0, 1)); in_b = rand_word();
        end
      end
      @(negedge clk);
      // Round robin: a lone requester wins; under contention the one not served last wins.
      eg_a = req_a && (!req_b || m_last_b);
      eg_b = req_b && (!req_a || !m_last_b);
      n_checks++;
      if (gnt_a !== eg_a || gnt_b !== eg_b) begin
        n_fail++;
        $display("FAIL rand_gnt @%0d: got a=%b b=%b, need a=%b b=%b", cyc, gnt_a, gnt_b, eg_a, eg_b);
      end
      e_busy = (due_qa.size() + due_qb.size()) > 0;
      ev_a = due_qa.size() > 0 && due_qa[0] == cyc;
      ev_b = due_qb.size() > 0 && due_qb[0] == cyc;
      ea = ev_a ? exp_qa[0] : last_a;
      eb = ev_b ? exp_qb[0] : last_b;
      n_checks++;
      if (rsp_vld_a !== ev_a || rsp_vld_b !== ev_b || rsp_a !== ea || rsp_b !== eb || busy !== e_busy) begin
        n_fail++;
        $display("FAIL rand_rsp @%0d: got va=%b vb=%b a=%h b=%h busy=%b, need va=%b vb=%b a=%h b=%h busy=%b",
                 cyc, rsp_vld_a, rsp_vld_b, rsp_a, rsp_b, busy, ev_a, ev_b, ea, eb, e_busy);
      end
      n_checks++;
      if (int'(cnt_a) != m_cnt_a || int'(cnt_b) != m_cnt_b) begin
        n_fail++;
        $display("FAIL rand_cnt @%0d: got a=%0d b=%0d, need a=%0d b=%0d", cyc, cnt_a, cnt_b,
                 m_cnt_a, m_cnt_b);
      end
      if (ev_a) begin last_a = exp_qa.pop_front(); void'(due_qa.pop_front()); end
      if (ev_b) begin last_b = exp_qb.pop_front(); void'(due_qb.pop_front()); end
      if (eg_a) begin
        exp_qa.push_back(ref_lookup(in_a)); due_qa.push_back(cyc + LAT);
        m_last_b = 1'b0; if (m_cnt_a < 15) m_cnt_a++;
      end
      if (eg_b) begin
        exp_qb.push_back(ref_lookup(in_b)); due_qb.push_back(cyc + LAT);
        m_last_b = 1'b1; if (m_cnt_b < 15) m_cnt_b++;
      end
      wait_a = (req_a && !eg_a) ? wait_a + 1 : 0;
      wait_b = (req_b && !eg_b) ? wait_b + 1 : 0;
      n_checks++;
      if (wait_a > 1 || wait_b > 1) begin
        n_fail++;
        $display("FAIL rand_starve @%0d: got wait_a=%0d wait_b=%0d, need <= 1", cyc, wait_a, wait_b);
      end
      pend_a = req_a && !eg_a;
      pend_b = req_b && !eg_b;
    end
    n_checks++;
    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d/%0d responses outstanding, need 0/0", exp_qa.size(), exp_qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_b_stream();
    test_reset_inflight();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
